// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe world model: map geometry, orientation and cell codes,
// FSM state encoding, and small pose helpers used by both the top and the sensor decoder.
package pipe_pkg;

  localparam int ROWS       = 10;
  localparam int COLS       = 20;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 5;
  localparam int MOVE_W     = 9;
  localparam int TRASH_HITS = 3;
  localparam int TRASH_W    = $clog2(TRASH_HITS + 1);

  typedef enum logic [1:0] {
    OR_N = 2'b00,
    OR_S = 2'b01,
    OR_E = 2'b10,
    OR_W = 2'b11
  } orient_t;

  typedef enum logic [2:0] {
    CELL_FREE    = 3'd0,
    CELL_WALL    = 3'd1,
    CELL_BARRIER = 3'd2,
    CELL_DIRT    = 3'd7
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } coord_t;

  // Map is stored 0-based; pose coordinates are 1-based, so lookups subtract one.
  typedef logic [2:0] map_t [ROWS][COLS];

  function automatic orient_t turn_left(orient_t o);
    case (o)
      OR_N:    return OR_W;
      OR_W:    return OR_S;
      OR_S:    return OR_E;
      default: return OR_N;
    endcase
  endfunction

  // The cell on the robot's left is the cell ahead after a left turn.
  function automatic coord_t step_from(coord_t p, orient_t o);
    coord_t n;
    n = p;
    case (o)
      OR_N:    n.row = p.row - ROW_W'(1);
      OR_S:    n.row = p.row + ROW_W'(1);
      OR_E:    n.col = p.col + COL_W'(1);
      default: n.col = p.col - COL_W'(1);
    endcase
    return n;
  endfunction

  function automatic logic on_map(coord_t p);
    return (p.row >= ROW_W'(1)) && (p.row <= ROW_W'(ROWS)) &&
           (p.col >= COL_W'(1)) && (p.col <= COL_W'(COLS));
  endfunction

endpackage

// File: rtl/pipe_world_model_if.sv
// Robot-facing handshake: the robot issues front/turn/remove, the world model answers with sensors.
interface pipe_world_model_if;

  logic front;
  logic turn;
  logic remove;
  logic head;
  logic left;
  logic under;
  logic barrier;

  modport master (
    output front, turn, remove,
    input  head, left, under, barrier
  );

  modport slave (
    input  front, turn, remove,
    output head, left, under, barrier
  );

endinterface

// File: rtl/pipe_sensor_decode.sv
// Combinational sensor view: from a pose and the map, derive the ahead/left/current cells and
// the four robot sensors. All sensors read 0 while inactive.
module pipe_sensor_decode
  import pipe_pkg::*;
(
  input  logic    active,
  input  coord_t  pos,
  input  orient_t orient,
  input  map_t    map,
  output coord_t  ahead,
  output logic    head,
  output logic    left,
  output logic    under,
  output logic    barrier
);

  coord_t     lft;
  logic       ahead_on;
  logic       left_on;
  logic       here_on;
  logic [2:0] ahead_cell;
  logic [2:0] left_cell;
  logic [2:0] here_cell;

  assign ahead    = step_from(pos, orient);
  assign lft      = step_from(pos, turn_left(orient));
  assign ahead_on = on_map(ahead);
  assign left_on  = on_map(lft);
  assign here_on  = on_map(pos);

  // Off-map coordinates must never index the array.
  always_comb begin
    ahead_cell = CELL_FREE;
    left_cell  = CELL_FREE;
    here_cell  = CELL_FREE;
    if (ahead_on) ahead_cell = map[ahead.row - ROW_W'(1)][ahead.col - COL_W'(1)];
    if (left_on)  left_cell  = map[lft.row - ROW_W'(1)][lft.col - COL_W'(1)];
    if (here_on)  here_cell  = map[pos.row - ROW_W'(1)][pos.col - COL_W'(1)];
  end

  always_comb begin
    head    = 1'b0;
    left    = 1'b0;
    under   = 1'b0;
    barrier = 1'b0;
    if (active) begin
      head    = !ahead_on || (ahead_cell == CELL_WALL);
      left    = !left_on || (left_cell == CELL_WALL);
      under   = here_on && (here_cell == CELL_DIRT);
      barrier = ahead_on && (ahead_cell == CELL_BARRIER);
    end
  end

endmodule

// File: rtl/pipe_world_model.sv
// Closed-loop environment for the pipe robot: owns the map and robot pose, feeds sensors to the
// robot, applies its move/turn/remove commands each RUN cycle, and flags completion or collisions.
module pipe_world_model
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ROW_W-1:0]  load_row,
  input  logic [COL_W-1:0]  load_col,
  input  logic [2:0]        load_data,
  input  logic              start,
  input  logic [ROW_W-1:0]  init_row,
  input  logic [COL_W-1:0]  init_col,
  input  logic [1:0]        init_orient,
  input  logic [MOVE_W-1:0] max_moves,
  pipe_world_model_if.slave bot,
  output logic [ROW_W-1:0]  robot_row,
  output logic [COL_W-1:0]  robot_col,
  output logic [1:0]        robot_orient,
  output logic [MOVE_W-1:0] move_count,
  output logic              trash_clr,
  output logic              done,
  output logic              fault
);

  localparam logic [TRASH_W-1:0] TRASH_LAST = TRASH_W'(TRASH_HITS - 1);

  state_t              state_q;
  state_t              state_d;
  map_t                map_q;
  coord_t              pos_q;
  coord_t              pos_d;
  orient_t             orient_q;
  orient_t             orient_d;
  logic [MOVE_W-1:0]   max_q;
  logic [MOVE_W-1:0]   move_count_q;
  logic [MOVE_W-1:0]   count_inc;
  logic [TRASH_W-1:0]  trash_cnt_q;
  logic                trash_clr_q;

  coord_t              ahead;
  logic                head_w;
  logic                left_w;
  logic                under_w;
  logic                barrier_w;

  logic                run;
  logic                collide;
  logic                start_ok;
  logic                trash_hit;
  logic                clr_fire;
  coord_t              init_pos;
  coord_t              load_pos;
  coord_t              tgt;
  logic                tgt_on;
  logic [2:0]          tgt_cell;

  pipe_sensor_decode u_decode (
    .active  (run),
    .pos     (pos_q),
    .orient  (orient_q),
    .map     (map_q),
    .ahead   (ahead),
    .head    (head_w),
    .left    (left_w),
    .under   (under_w),
    .barrier (barrier_w)
  );

  assign run       = (state_q == ST_RUN);
  assign init_pos  = {init_row, init_col};
  assign load_pos  = {load_row, load_col};
  assign start_ok  = on_map(init_pos);
  assign count_inc = move_count_q + MOVE_W'(1);
  assign collide   = run && bot.front && (head_w || barrier_w);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_d_apply: state_q <= state_d;
  end

  // A collision wins over reaching the move budget in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (collide)                 state_d = ST_FAULT;
        else if (count_inc == max_q) state_d = ST_DONE;
      end
      default: begin
        if (start) begin
          if (!start_ok)                state_d = ST_FAULT;
          else if (max_moves == '0)     state_d = ST_DONE;
          else                          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    pos_d    = pos_q;
    orient_d = orient_q;
    if (run && !collide) begin
      if (bot.front)     pos_d    = ahead;
      else if (bot.turn) orient_d = turn_left(orient_q);
    end
  end

  // The clear target is the cell ahead of the pose after this cycle's move or turn.
  assign tgt    = step_from(pos_d, orient_d);
  assign tgt_on = on_map(tgt);

  always_comb begin
    tgt_cell = CELL_FREE;
    if (tgt_on) tgt_cell = map_q[tgt.row - ROW_W'(1)][tgt.col - COL_W'(1)];
  end

  assign trash_hit = run && !collide && bot.remove && (trash_cnt_q == TRASH_LAST);
  assign clr_fire  = trash_hit && tgt_on && (tgt_cell == CELL_BARRIER);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_q        <= '0;
      orient_q     <= OR_N;
      max_q        <= '0;
      move_count_q <= '0;
      trash_cnt_q  <= '0;
      trash_clr_q  <= 1'b0;
    end else begin
      trash_clr_q <= clr_fire;
      if (run) begin
        move_count_q <= count_inc;
        pos_q        <= pos_d;
        orient_q     <= orient_d;
        if (!collide && bot.remove) begin
          trash_cnt_q <= trash_hit ? '0 : trash_cnt_q + TRASH_W'(1);
        end
      end else if (start) begin
        move_count_q <= '0;
        trash_cnt_q  <= '0;
        if (start_ok) begin
          pos_q    <= init_pos;
          orient_q <= orient_t'(init_orient);
          max_q    <= max_moves;
        end
      end
    end
  end

  // Loads are only accepted outside RUN, so they can never collide with a trash clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          map_q[r][c] <= CELL_FREE;
        end
      end
    end else if (clr_fire) begin
      map_q[tgt.row - ROW_W'(1)][tgt.col - COL_W'(1)] <= CELL_FREE;
    end else if (!run && load_en && on_map(load_pos)) begin
      map_q[load_pos.row - ROW_W'(1)][load_pos.col - COL_W'(1)] <= load_data;
    end
  end

  assign bot.head     = head_w;
  assign bot.left     = left_w;
  assign bot.under    = under_w;
  assign bot.barrier  = barrier_w;
  assign robot_row    = pos_q.row;
  assign robot_col    = pos_q.col;
  assign robot_orient = orient_q;
  assign move_count   = move_count_q;
  assign trash_clr    = trash_clr_q;
  assign done         = (state_q == ST_DONE);
  assign fault        = (state_q == ST_FAULT);

endmodule
